// File: rtl/bsg_fifos_to_axil.sv
// AXI-Lite master: converts a ready/valid request stream into single AXI-Lite
// read/write transactions and returns each response on a ready/valid stream.
module bsg_fifos_to_axil #(
    parameter int addr_width_p           = 32,
    parameter int data_width_p           = 32,
    parameter int axil_mosi_bus_width_lp = 2*addr_width_p + data_width_p + data_width_p/8 + 5,
    parameter int axil_miso_bus_width_lp = data_width_p + 9
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    output logic [axil_mosi_bus_width_lp-1:0] m_axil_bus_o,
    input  logic [axil_miso_bus_width_lp-1:0] m_axil_bus_i,

    input  logic                              req_v_i,
    input  logic                              req_write_i,
    input  logic [addr_width_p-1:0]           req_addr_i,
    input  logic [data_width_p-1:0]           req_data_i,
    output logic                              req_ready_o,

    output logic                              resp_v_o,
    output logic                              resp_write_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic [1:0]                        resp_err_o,
    input  logic                              resp_yumi_i,

    output logic                              busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RESP    = 3'd5
    } state_e;

    // Bus packing, MSB first:
    //   mosi = {awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready}
    //   miso = {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid}
    logic                    awready, wready, bvalid, arready, rvalid;
    logic [1:0]              bresp, rresp;
    logic [data_width_p-1:0] rdata;

    assign {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid} = m_axil_bus_i;

    state_e                  state_q, state_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [data_width_p-1:0] data_q, data_d;
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_pend_q, w_pend_d;
    logic                    resp_write_q, resp_write_d;
    logic [data_width_p-1:0] resp_data_q, resp_data_d;
    logic [1:0]              resp_err_q, resp_err_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            resp_write_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            aw_pend_q    <= aw_pend_d;
            w_pend_q     <= w_pend_d;
            resp_write_q <= resp_write_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        aw_pend_d    = aw_pend_q;
        w_pend_d     = w_pend_q;
        resp_write_d = resp_write_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_v_i) begin
                    addr_d = req_addr_i;
                    data_d = req_data_i;
                    if (req_write_i) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        state_d   = RD_ADDR;
                    end
                end
            end
            WRITE: begin
                // Each channel retires independently; leave once both have retired.
                if (aw_pend_q && awready) aw_pend_d = 1'b0;
                if (w_pend_q && wready)   w_pend_d  = 1'b0;
                if (!aw_pend_d && !w_pend_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    resp_err_d   = bresp;
                    resp_write_d = 1'b1;
                    resp_data_d  = '0;
                    state_d      = RESP;
                end
            end
            RD_ADDR: begin
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) begin
                    resp_data_d  = rdata;
                    resp_err_d   = rresp;
                    resp_write_d = 1'b0;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic                        awvalid, wvalid, bready, arvalid, rready;
    logic [data_width_p/8-1:0]   wstrb;

    assign awvalid = (state_q == WRITE) && aw_pend_q;
    assign wvalid  = (state_q == WRITE) && w_pend_q;
    assign bready  = (state_q == WR_RESP);
    assign arvalid = (state_q == RD_ADDR);
    assign rready  = (state_q == RD_DATA);
    assign wstrb   = '1;

    assign m_axil_bus_o = {addr_q, awvalid, data_q, wstrb, wvalid, bready,
                           addr_q, arvalid, rready};

    assign req_ready_o  = (state_q == IDLE) && !reset_i;
    assign resp_v_o     = (state_q == RESP);
    assign resp_write_o = resp_write_q;
    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_bsg_fifos_to_axil.sv
// Scoreboard bench for bsg_fifos_to_axil: a behavioural AXI-Lite slave with
// programmable delays, expected-value queues, and a negedge monitor.
module tb_bsg_fifos_to_axil;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int MOSI_W = 2*AW + DW + DW/8 + 5;
    localparam int MISO_W = DW + 9;

    logic              clk = 1'b0;
    logic              reset_i;
    logic [MOSI_W-1:0] m_axil_bus_o;
    logic [MISO_W-1:0] m_axil_bus_i;
    logic              req_v_i, req_write_i, req_ready_o;
    logic [AW-1:0]     req_addr_i;
    logic [DW-1:0]     req_data_i;
    logic              resp_v_o, resp_write_o, resp_yumi_i, busy_o;
    logic [DW-1:0]     resp_data_o;
    logic [1:0]        resp_err_o;

    always #5 clk = ~clk;

    bsg_fifos_to_axil #(
        .addr_width_p(AW),
        .data_width_p(DW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .m_axil_bus_o (m_axil_bus_o),
        .m_axil_bus_i (m_axil_bus_i),
        .req_v_i      (req_v_i),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .resp_v_o     (resp_v_o),
        .resp_write_o (resp_write_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .resp_yumi_i  (resp_yumi_i),
        .busy_o       (busy_o)
    );

    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          awvalid, wvalid, bready, arvalid, rready;
    assign {awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready} = m_axil_bus_o;

    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;
    assign m_axil_bus_i = {awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid};

    int unsigned aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;
    bit          auto_yumi;

    typedef struct packed {
        logic        wr;
        logic [31:0] data;
        logic [1:0]  err;
    } resp_t;

    resp_t       exp_resp[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_ar[$];

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Slave: each ready/valid responder waits its programmed delay while the
    // master holds its valid/ready, then asserts for one handshake.
    initial begin
        int unsigned awc, wc, bc, arc, rc;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid && !awready) begin
                if (awc >= aw_dly) awready = 1; else awc++;
            end else begin awready = 0; awc = 0; end
            if (wvalid && !wready) begin
                if (wc >= w_dly) wready = 1; else wc++;
            end else begin wready = 0; wc = 0; end
            if (bready && !bvalid) begin
                if (bc >= b_dly) begin bvalid = 1; bresp = cfg_bresp; end else bc++;
            end else begin bvalid = 0; bc = 0; end
            if (arvalid && !arready) begin
                if (arc >= ar_dly) arready = 1; else arc++;
            end else begin arready = 0; arc = 0; end
            if (rready && !rvalid) begin
                if (rc >= r_dly) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; end else rc++;
            end else begin rvalid = 0; rc = 0; end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (auto_yumi) resp_yumi_i = resp_v_o;
        end
    end

    // Monitor: handshakes are sampled mid-cycle and retire at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_i) begin
                if (awvalid && awready) begin
                    if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                    else chk("aw_addr", awaddr, exp_aw.pop_front());
                end
                if (wvalid && wready) begin
                    if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                    else begin
                        chk("w_data", wdata, exp_w.pop_front());
                        chk("w_strb", wstrb, 4'hF);
                    end
                end
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                    else chk("ar_addr", araddr, exp_ar.pop_front());
                end
                if (resp_v_o && resp_yumi_i) begin
                    if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
                    else chk("resp", {resp_write_o, resp_data_o, resp_err_o}, exp_resp.pop_front());
                end
            end
        end
    end

    task automatic issue_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input bit push_resp, input logic [31:0] rd, input logic [1:0] err);
        bit acc;
        acc = 0;
        @(posedge clk); #1;
        if (wr) begin exp_aw.push_back(a); exp_w.push_back(d); end
        else exp_ar.push_back(a);
        if (push_resp) exp_resp.push_back({wr, (wr ? 32'h0 : rd), err});
        req_v_i = 1; req_write_i = wr; req_addr_i = a; req_data_i = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready_o) begin acc = 1; break; end
        end
        @(posedge clk); #1;
        req_v_i = 0;
        if (!acc) chk("req_accept_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_resp.size() == 0 && exp_aw.size() == 0 && exp_w.size() == 0 &&
                exp_ar.size() == 0 && !busy_o) begin
                done = 1;
                break;
            end
        end
        chk(name, done, 1);
    endtask

    task automatic set_dly(input int unsigned a, input int unsigned w, input int unsigned b,
                           input int unsigned ar, input int unsigned r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset_i = 1; req_v_i = 0; req_write_i = 0; req_addr_i = 0; req_data_i = 0;
        resp_yumi_i = 0; auto_yumi = 1;
        set_dly(0, 0, 0, 0, 0);
        cfg_bresp = 0; cfg_rresp = 0; cfg_rdata = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_state", {busy_o, resp_v_o, awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rst_resp_regs", {resp_write_o, resp_data_o, resp_err_o}, 0);
        @(posedge clk); #1 reset_i = 0;
        @(negedge clk);
        chk("idle_req_ready", req_ready_o, 1);

        // Write, AW ready after 2 cycles, W afterwards
        set_dly(2, 3, 0, 0, 0);
        issue_req(1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 2'b00);
        drain("write_done");

        // Zero-wait read; arvalid must be up in the first cycle after acceptance
        set_dly(0, 0, 0, 0, 0);
        cfg_rdata = 32'h0000_0010; cfg_rresp = 2'b00;
        issue_req(0, 32'h0000_0024, 32'h0, 1, 32'h0000_0010, 2'b00);
        @(negedge clk);
        chk("read_latency_arvalid", arvalid, 1);
        drain("read_done");

        // W completes well before AW
        set_dly(3, 0, 0, 0, 0);
        issue_req(1, 32'h0000_0080, 32'h1234_5678, 1, 0, 2'b00);
        @(negedge clk);
        chk("w_first_both_valid", {awvalid, wvalid}, 2'b11);
        @(negedge clk);
        chk("w_first_w_dropped", {awvalid, wvalid}, 2'b10);
        drain("w_first_done");

        // DECERR read passes straight through
        set_dly(0, 0, 0, 1, 2);
        cfg_rdata = 32'hBEEF_DEAD; cfg_rresp = 2'b11;
        issue_req(0, 32'hFFFF_FFF0, 32'h0, 1, 32'hBEEF_DEAD, 2'b11);
        drain("decerr_done");
        chk("decerr_idle", {busy_o, req_ready_o}, 2'b01);

        // Response held for 5 cycles with a pending request behind it
        set_dly(0, 0, 0, 0, 0);
        cfg_rresp = 2'b00; cfg_bresp = 2'b00;
        auto_yumi = 0;
        issue_req(1, 32'h0000_0040, 32'hA5A5_0040, 1, 0, 2'b00);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (resp_v_o) begin seen = 1; break; end
        end
        chk("hold_resp_seen", seen, 1);
        cfg_rdata = 32'hCAFE_0050;
        exp_ar.push_back(32'h0000_0050);
        exp_resp.push_back({1'b0, 32'hCAFE_0050, 2'b00});
        req_v_i = 1; req_write_i = 0; req_addr_i = 32'h0000_0050; req_data_i = 0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_req_ready", req_ready_o, 0);
            chk("hold_resp", {resp_v_o, resp_write_o, resp_data_o, resp_err_o}, {2'b11, 32'h0, 2'b00});
            chk("hold_bus_idle", {awvalid, wvalid, bready, arvalid, rready}, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 resp_yumi_i = 1;
        @(posedge clk); #1 resp_yumi_i = 0;
        @(negedge clk);
        chk("after_yumi_idle", {busy_o, req_ready_o}, 2'b01);
        @(posedge clk); #1 req_v_i = 0;
        @(negedge clk);
        chk("next_req_accepted", {busy_o, arvalid}, 2'b11);
        auto_yumi = 1;
        drain("hold_done");

        // Reset while waiting on B
        set_dly(0, 0, 5, 0, 0);
        issue_req(1, 32'h0000_0060, 32'h0000_0066, 0, 0, 2'b00);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bready) begin seen = 1; break; end
        end
        chk("rst_mid_in_wr_resp", seen, 1);
        @(posedge clk); #1 reset_i = 1;
        @(negedge clk);
        chk("rst_mid_req_ready_low", req_ready_o, 0);
        @(posedge clk); #1 reset_i = 0;
        @(negedge clk);
        chk("rst_mid_cleared", {awvalid, wvalid, bready, arvalid, rready, resp_v_o, busy_o}, 0);
        chk("rst_mid_req_ready", req_ready_o, 1);
        set_dly(0, 0, 0, 0, 0);
        cfg_rdata = 32'h0000_0077;
        issue_req(0, 32'h0000_0070, 32'h0, 1, 32'h0000_0077, 2'b00);
        drain("post_reset_read_done");

        chk("left_resp", exp_resp.size(), 0);
        chk("left_aw", exp_aw.size(), 0);
        chk("left_w", exp_w.size(), 0);
        chk("left_ar", exp_ar.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
